cmos_capture_rgb565: RTL

Camera capture front end feeding the SDRAM frame buffer. Runs in the OV7670 pixel-clock domain; it pairs 8-bit sensor bytes into RGB565 words and discards the first frames after configuration. It also bounds each frame to the 480x272 window and drives the write-side user interface (`sys_we`, `sys_data_in`, `frame_valid`) of the SDRAM/LCD top. It flags frames whose geometry is wrong.

---
 rtl/cmos_capture_pkg.sv | 21 ++
 rtl/cmos_byte_pack.sv | 55 +++++
 rtl/cmos_capture_rgb565.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmos_capture_pkg.sv
// Shared definitions for the OV7670 RGB565 capture front end:
// FSM encoding, default LCD window geometry and frame-skip count.
package cmos_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        SKIP      = 2'd1,
        CAPTURE   = 2'd2
    } cap_state_t;

    localparam int LCD_H          = 480;
    localparam int LCD_V          = 272;
    localparam int FRAME_SKIP_DEF = 10;

    localparam int BYTE_W     = 8;
    localparam int PIXEL_W    = 16;
    localparam int PIX_CNT_W  = 11;
    localparam int LINE_CNT_W = 10;
    localparam int SKIP_CNT_W = 8;

endpackage

// File: rtl/cmos_byte_pack.sv
// Registers the raw sensor pins, detects sync edges on the registered copies
// and pairs consecutive HREF bytes into one RGB565 pixel.
module cmos_byte_pack
    import cmos_capture_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               href,
    input  logic [BYTE_W-1:0]  data,
    output logic               href_d,
    output logic               byte_flag,
    output logic               vs_rise,
    output logic               vs_fall,
    output logic               href_fall,
    output logic               pixel_done,
    output logic [PIXEL_W-1:0] pixel
);

    logic              vsync_d;
    logic              vsync_d2;
    logic              href_d2;
    logic [BYTE_W-1:0] data_d;
    logic [BYTE_W-1:0] high_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            vsync_d2  <= 1'b0;
            href_d    <= 1'b0;
            href_d2   <= 1'b0;
            data_d    <= '0;
            byte_flag <= 1'b0;
            high_byte <= '0;
        end else begin
            vsync_d   <= vsync;
            vsync_d2  <= vsync_d;
            href_d    <= href;
            href_d2   <= href_d;
            data_d    <= data;
            // An odd trailing byte leaves byte_flag=1 into the href_fall cycle.
            byte_flag <= href_d ? ~byte_flag : 1'b0;
            if (href_d && !byte_flag) begin
                high_byte <= data_d;
            end
        end
    end

    assign vs_rise    = vsync_d & ~vsync_d2;
    assign vs_fall    = ~vsync_d & vsync_d2;
    assign href_fall  = ~href_d & href_d2;
    assign pixel_done = href_d & byte_flag;
    assign pixel      = {high_byte, data_d};

endmodule

// File: rtl/cmos_capture_rgb565.sv
// Camera capture top: skips the first frames after init, windows each frame
// to H_PIXELS x V_LINES, drives the frame-buffer write side and flags bad frames.
module cmos_capture_rgb565
    import cmos_capture_pkg::*;
#(
    parameter int H_PIXELS   = LCD_H,
    parameter int V_LINES    = LCD_V,
    parameter int FRAME_SKIP = FRAME_SKIP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmos_init_done,
    input  logic               sdram_init_done,
    input  logic               cmos_vsync,
    input  logic               cmos_href,
    input  logic [BYTE_W-1:0]  cmos_data,
    output logic               frame_clken,
    output logic [PIXEL_W-1:0] frame_data,
    output logic               frame_valid,
    output logic               frame_err
);

    localparam logic [PIX_CNT_W-1:0]  H_LIM    = PIX_CNT_W'(H_PIXELS);
    localparam logic [LINE_CNT_W-1:0] V_LIM    = LINE_CNT_W'(V_LINES);
    localparam logic [SKIP_CNT_W-1:0] SKIP_LIM = SKIP_CNT_W'(FRAME_SKIP);

    logic               href_d;
    logic               byte_flag;
    logic               vs_rise;
    logic               vs_fall;
    logic               href_fall;
    logic               pixel_done;
    logic [PIXEL_W-1:0] pixel;

    cmos_byte_pack u_byte_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (cmos_vsync),
        .href       (cmos_href),
        .data       (cmos_data),
        .href_d     (href_d),
        .byte_flag  (byte_flag),
        .vs_rise    (vs_rise),
        .vs_fall    (vs_fall),
        .href_fall  (href_fall),
        .pixel_done (pixel_done),
        .pixel      (pixel)
    );

    cap_state_t              state;
    cap_state_t              state_next;
    logic [SKIP_CNT_W-1:0]   skip_cnt;
    logic [SKIP_CNT_W-1:0]   skip_next;
    logic [PIX_CNT_W-1:0]    pixel_cnt;
    logic [LINE_CNT_W-1:0]   line_cnt;
    logic                    line_err;

    logic init_ok;
    logic pix_write;
    logic line_end;
    logic line_bad;
    logic frame_bad;

    assign init_ok = cmos_init_done & sdram_init_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_INIT;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        if (!init_ok) begin
            state_next = WAIT_INIT;
            skip_next  = '0;
        end else begin
            case (state)
                WAIT_INIT: begin
                    state_next = SKIP;
                    skip_next  = '0;
                end
                SKIP: begin
                    if (vs_rise) begin
                        skip_next = skip_cnt + 1'b1;
                        if (skip_cnt + 1'b1 == SKIP_LIM) begin
                            state_next = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    state_next = CAPTURE;
                end
                default: begin
                    state_next = WAIT_INIT;
                    skip_next  = '0;
                end
            endcase
        end
    end

    // Gating uses the pre-edge frame_valid, so a pixel completing on vs_rise is still written.
    assign pix_write = pixel_done & init_ok & (state == CAPTURE) & frame_valid
                     & (pixel_cnt < H_LIM) & (line_cnt < V_LIM);

    // A VSYNC arriving mid-line closes that line as if HREF had dropped.
    assign line_end  = href_fall | (vs_rise & href_d);
    assign line_bad  = line_end & ((pixel_cnt != H_LIM) | byte_flag);
    assign frame_bad = line_err | line_bad | (line_cnt != V_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_cnt   <= '0;
            line_cnt    <= '0;
            line_err    <= 1'b0;
            frame_clken <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_clken <= pix_write;
            if (pix_write) begin
                frame_data <= pixel;
            end

            if (vs_rise || href_fall) begin
                pixel_cnt <= '0;
            end else if (pixel_done && pixel_cnt != '1) begin
                pixel_cnt <= pixel_cnt + 1'b1;
            end

            if (vs_rise) begin
                line_cnt <= '0;
            end else if (href_fall && pixel_cnt != '0 && line_cnt != '1) begin
                line_cnt <= line_cnt + 1'b1;
            end

            if (vs_rise) begin
                line_err <= 1'b0;
            end else if (line_bad) begin
                line_err <= 1'b1;
            end

            frame_err <= vs_rise & init_ok & (state == CAPTURE) & frame_valid & frame_bad;

            if (!init_ok || state != CAPTURE || vs_rise) begin
                frame_valid <= 1'b0;
            end else if (vs_fall) begin
                frame_valid <= 1'b1;
            end
        end
    end

endmodule
